fetch_decode_ctrl: RTL and testbench

- Owns the PC register, the IF/ID pipeline register and the ID/EX valid bit of the 5-stage RV32I pipeline.
- Consumes the hazard detector's is_stall (load-use and ecall-x17 hazards), EX-stage redirects and the ID-stage halt request.
- Decides each cycle whether to advance, hold, bubble, flush or drain the front end.
- Drives instruction-memory address and the is_halted flag seen by the testbench.

---
 rtl/fetch_decode_ctrl_pkg.sv | 20 ++
 rtl/fetch_decode_ctrl_halt_drain_fsm.sv | 71 +++++++
 rtl/fetch_decode_ctrl.sv | 108 ++++++++++
 tb/tb_fetch_decode_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_ctrl_pkg.sv
// Shared front-end definitions for the 5-stage RV32I pipeline.
// The fetch/decode controller and the ID-stage halt detection both use these.
package fetch_decode_ctrl_pkg;

  typedef enum logic [1:0] {
    FE_RUN    = 2'd0,
    FE_DRAIN  = 2'd1,
    FE_HALTED = 2'd2
  } fe_state_e;

  localparam logic [31:0] NOP_INST      = 32'h0000_0013;
  localparam logic [31:0] ECALL_HALT_ID = 32'd10;
  localparam int unsigned DRAIN_CNT_W   = 3;

  // ID uses this on the forwarded x17 value to qualify an ecall as a halt.
  function automatic logic is_halt_ecall(input logic [31:0] a7_value);
    return (a7_value == ECALL_HALT_ID);
  endfunction

endpackage

// File: rtl/fetch_decode_ctrl_halt_drain_fsm.sv
// Halt sequencer: RUN -> DRAIN (count down while the ecall retires) -> HALTED.
// accept is the halt candidate, start says the front end is free to act on it.
module halt_drain_fsm
  import fetch_decode_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic accept,
  input  logic start,
  output logic draining,
  output logic halted
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_INIT = DRAIN_CNT_W'(DRAIN_CYCLES);

  fe_state_e              state_q, state_d;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic                   halted_q, halted_d;

  // Next-state and drain countdown.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    halted_d    = halted_q;
    case (state_q)
      FE_RUN: begin
        if (accept && start) begin
          state_d     = FE_DRAIN;
          drain_cnt_d = DRAIN_INIT;
        end else begin
          state_d     = FE_RUN;
        end
      end
      FE_DRAIN: begin
        if (drain_cnt_q == 3'd1) begin
          state_d  = FE_HALTED;
          halted_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q - 3'd1;
        end
      end
      FE_HALTED: begin
        state_d = FE_HALTED;
      end
      default: begin
        state_d     = FE_RUN;
        drain_cnt_d = 3'd0;
        halted_d    = 1'b0;
      end
    endcase
  end

  // State, counter and halted flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FE_RUN;
      drain_cnt_q <= 3'd0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halted_q    <= halted_d;
    end
  end

  assign draining = (state_q == FE_DRAIN);
  assign halted   = halted_q;

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Front-end controller: PC, IF/ID register and the ID/EX valid bit.
// Chooses advance / hold / bubble / flush / drain every cycle.
module fetch_decode_ctrl #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = {XLEN{1'b0}},
  parameter int unsigned     DRAIN_CYCLES = 3,
  parameter logic [31:0]     NOP_INST     = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            is_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_inst,
  output logic            if_id_valid,
  output logic            id_ex_valid,
  output logic            is_halted
);

  import fetch_decode_ctrl_pkg::*;

  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
  logic [31:0]     if_id_inst_q, if_id_inst_d;
  logic            if_id_valid_q, if_id_valid_d;
  logic            id_ex_valid_q, id_ex_valid_d;
  logic            draining_s, halted_s, accept_s, start_s;

  // A halt is only a candidate when ID holds a real ecall; redirect and stall outrank it.
  assign accept_s = halt_req && if_id_valid_q;
  assign start_s  = !redirect_valid && !is_stall;

  halt_drain_fsm #(
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_halt_drain_fsm (
    .clk     (clk),
    .reset_n (reset_n),
    .accept  (accept_s),
    .start   (start_s),
    .draining(draining_s),
    .halted  (halted_s)
  );

  // Front-end action selection in priority order.
  always_comb begin
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_inst_d  = if_id_inst_q;
    if_id_valid_d = if_id_valid_q;
    id_ex_valid_d = id_ex_valid_q;
    if (halted_s) begin
      pc_d = pc_q;
    end else if (draining_s) begin
      if_id_valid_d = 1'b0;
      if_id_inst_d  = NOP_INST;
      id_ex_valid_d = 1'b0;
    end else if (redirect_valid) begin
      // ID holds a wrong-path instruction, so it is squashed along with any stall or halt.
      pc_d          = redirect_pc;
      if_id_valid_d = 1'b0;
      if_id_inst_d  = NOP_INST;
      id_ex_valid_d = 1'b0;
    end else if (is_stall) begin
      id_ex_valid_d = 1'b0;
    end else if (accept_s) begin
      if_id_valid_d = 1'b0;
      if_id_inst_d  = NOP_INST;
      id_ex_valid_d = 1'b1;
    end else begin
      if_id_inst_d  = imem_rdata;
      if_id_pc_d    = pc_q;
      if_id_valid_d = 1'b1;
      pc_d          = pc_q + PC_STEP;
      id_ex_valid_d = if_id_valid_q;
    end
  end

  // PC and pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      if_id_pc_q    <= {XLEN{1'b0}};
      if_id_inst_q  <= NOP_INST;
      if_id_valid_q <= 1'b0;
      id_ex_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_valid_q <= if_id_valid_d;
      id_ex_valid_q <= id_ex_valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_inst  = if_id_inst_q;
  assign if_id_valid = if_id_valid_q;
  assign id_ex_valid = id_ex_valid_q;
  assign is_halted   = halted_s;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Bench for fetch_decode_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_fetch_decode_ctrl;

  localparam int          DC  = 3;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        is_stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        halt_req = 1'b0;
  logic [31:0] imem_rdata, imem_addr, if_id_pc, if_id_inst;
  logic        if_id_valid, id_ex_valid, is_halted;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h1357_9BD0;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_decode_ctrl #(
    .XLEN(32), .RESET_PC(32'h0000_0000), .DRAIN_CYCLES(DC), .NOP_INST(NOP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .is_stall(is_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .imem_rdata(imem_rdata), .imem_addr(imem_addr),
    .if_id_pc(if_id_pc), .if_id_inst(if_id_inst), .if_id_valid(if_id_valid),
    .id_ex_valid(id_ex_valid), .is_halted(is_halted)
  );

  // Behavioural model: halting is tracked as "edge of acceptance", not as a counter.
  logic [31:0] m_pc, m_ifpc, m_ifinst;
  logic        m_ifv, m_idex, m_halted;
  int          edges, acc_edge;
  int          n_checks = 0, n_pass = 0;
  logic        cmp_en = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] mdl,
                     input logic [31:0] exp);
    check32({name, "_dut"}, act, exp);
    check32({name, "_mdl"}, mdl, exp);
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_ifpc = 32'd0; m_ifinst = NOP;
    m_ifv = 1'b0; m_idex = 1'b0; m_halted = 1'b0;
    edges = 0; acc_edge = -1;
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
      return;
    end
    edges++;
    if (acc_edge >= 0) begin
      if (edges <= acc_edge + DC) begin
        m_ifv = 1'b0; m_idex = 1'b0;
        if (edges == acc_edge + DC) m_halted = 1'b1;
      end
      return;
    end
    if (redirect_valid) begin
      m_pc = redirect_pc; m_ifv = 1'b0; m_ifinst = NOP; m_idex = 1'b0;
    end else if (is_stall) begin
      m_idex = 1'b0;
    end else if (halt_req && m_ifv) begin
      m_ifv = 1'b0; m_ifinst = NOP; m_idex = 1'b1; acc_edge = edges;
    end else begin
      m_idex = m_ifv; m_ifinst = mem_word(m_pc); m_ifpc = m_pc; m_ifv = 1'b1;
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    tick();
    reset_n = 1'b1;
  endtask

  // Per-cycle compare of every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check32("imem_addr", imem_addr, m_pc);
      check32("if_id_pc", if_id_pc, m_ifpc);
      check32("if_id_inst", if_id_inst, m_ifinst);
      check32("if_id_valid", 32'(if_id_valid), 32'(m_ifv));
      check32("id_ex_valid", 32'(id_ex_valid), 32'(m_idex));
      check32("is_halted", 32'(is_halted), 32'(m_halted));
    end
  end

  initial begin
    logic [31:0] r;
    model_reset();
    tick();
    tick();
    cmp_en = 1'b1;
    reset_n = 1'b1;
    lit("rst_addr", imem_addr, m_pc, 32'h0);
    lit("rst_ifv", 32'(if_id_valid), 32'(m_ifv), 32'd0);
    lit("rst_inst", if_id_inst, m_ifinst, NOP);
    lit("rst_halted", 32'(is_halted), 32'(m_halted), 32'd0);

    // Free-running fetch.
    tick();
    lit("e1_addr", imem_addr, m_pc, 32'h4);
    lit("e1_ifv", 32'(if_id_valid), 32'(m_ifv), 32'd1);
    lit("e1_idex", 32'(id_ex_valid), 32'(m_idex), 32'd0);
    tick();
    lit("e2_addr", imem_addr, m_pc, 32'h8);
    lit("e2_idex", 32'(id_ex_valid), 32'(m_idex), 32'd1);
    tick();
    tick();
    lit("e4_addr", imem_addr, m_pc, 32'h10);
    lit("e4_ifpc", if_id_pc, m_ifpc, 32'hC);

    // Two-cycle stall at pc 0x10.
    is_stall = 1'b1;
    tick();
    lit("st1_addr", imem_addr, m_pc, 32'h10);
    lit("st1_idex", 32'(id_ex_valid), 32'(m_idex), 32'd0);
    tick();
    lit("st2_ifpc", if_id_pc, m_ifpc, 32'hC);
    lit("st2_inst", if_id_inst, m_ifinst, mem_word(32'hC));
    is_stall = 1'b0;
    tick();
    lit("st_res_addr", imem_addr, m_pc, 32'h14);
    lit("st_res_idex", 32'(id_ex_valid), 32'(m_idex), 32'd1);

    // Redirect overrides a concurrent stall.
    redirect_valid = 1'b1; redirect_pc = 32'h100; is_stall = 1'b1;
    tick();
    lit("rd_addr", imem_addr, m_pc, 32'h100);
    lit("rd_ifv", 32'(if_id_valid), 32'(m_ifv), 32'd0);
    lit("rd_idex", 32'(id_ex_valid), 32'(m_idex), 32'd0);
    is_stall = 1'b0; redirect_pc = 32'h1C;
    tick();
    redirect_valid = 1'b0;
    tick();
    lit("pre_halt_addr", imem_addr, m_pc, 32'h20);

    // Halt accepted at pc 0x20; disturbances during drain are ignored.
    halt_req = 1'b1;
    tick();
    lit("acc_addr", imem_addr, m_pc, 32'h20);
    lit("acc_idex", 32'(id_ex_valid), 32'(m_idex), 32'd1);
    halt_req = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200; is_stall = 1'b1;
    tick();
    lit("dr1_idex", 32'(id_ex_valid), 32'(m_idex), 32'd0);
    redirect_valid = 1'b0; is_stall = 1'b0;
    tick();
    lit("dr2_halted", 32'(is_halted), 32'(m_halted), 32'd0);
    tick();
    lit("dr3_halted", 32'(is_halted), 32'(m_halted), 32'd1);
    tick();
    tick();
    lit("hlt_addr", imem_addr, m_pc, 32'h20);

    // Halt request held off by a one-cycle stall.
    do_reset();
    tick();
    tick();
    halt_req = 1'b1; is_stall = 1'b1;
    tick();
    lit("hs_idex", 32'(id_ex_valid), 32'(m_idex), 32'd0);
    lit("hs_ifv", 32'(if_id_valid), 32'(m_ifv), 32'd1);
    is_stall = 1'b0;
    tick();
    lit("hs_acc_idex", 32'(id_ex_valid), 32'(m_idex), 32'd1);
    halt_req = 1'b0;
    tick();
    tick();
    lit("hs_halted_early", 32'(is_halted), 32'(m_halted), 32'd0);
    tick();
    lit("hs_halted", 32'(is_halted), 32'(m_halted), 32'd1);

    // Reset in the middle of the drain leaves no residual count.
    do_reset();
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    reset_n = 1'b0;
    model_reset();
    #1;
    lit("mr_addr", imem_addr, m_pc, 32'h0);
    lit("mr_halted", 32'(is_halted), 32'(m_halted), 32'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    lit("mr_run_addr", imem_addr, m_pc, 32'h10);
    lit("mr_run_halted", 32'(is_halted), 32'(m_halted), 32'd0);

    // Randomized traffic, including redirects near the top of the address space.
    for (int i = 0; i < 4000; i++) begin
      is_stall       = ($urandom_range(0, 99) < 20);
      redirect_valid = ($urandom_range(0, 99) < 8);
      halt_req       = ($urandom_range(0, 99) < 6);
      r = $urandom();
      redirect_pc    = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF8 : {r[31:2], 2'b00};
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) do_reset();
      else tick();
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
